// File: rtl/mastermind_pkg.sv
// Shared types, default parameters and helpers for the Mastermind engine.
// Optional history buffer is enabled with the MASTERMIND_HISTORY_EN macro.
package mastermind_pkg;

  // Scoring flow: IDLE until the first new_game, then READY/COUNT/MATCH per guess.
  typedef enum logic [2:0] {
    StIdle,
    StReady,
    StCount,
    StMatch,
    StDone
  } state_e;

  localparam int unsigned DefPegs     = 4;
  localparam int unsigned DefColorW   = 3;
  localparam int unsigned DefMaxTurns = 8;

  // Upper bounds for the generic peg extractor; codes wider than this are not supported.
  localparam int unsigned MaxCodeW  = 256;
  localparam int unsigned MaxColorW = 16;

  // Counter wide enough to hold 0..pegs.
  function automatic int unsigned cnt_width(input int unsigned pegs);
    return $clog2(pegs + 1);
  endfunction

  // Counter wide enough to hold 0..max_turns.
  function automatic int unsigned turn_width(input int unsigned max_turns);
    return $clog2(max_turns + 1);
  endfunction

  // Colour of peg idx in a packed code (peg i at [i*color_w +: color_w]).
  function automatic logic [MaxColorW-1:0] peg_at(input logic [MaxCodeW-1:0] code,
                                                  input int unsigned idx,
                                                  input int unsigned color_w);
    logic [MaxCodeW-1:0] shifted;
    logic [MaxCodeW-1:0] mask;
    shifted = code >> (idx * color_w);
    mask    = ~({MaxCodeW{1'b1}} << color_w);
    return MaxColorW'(shifted & mask);
  endfunction

endpackage

// File: rtl/mastermind_hist_ram.sv
// Per-turn history register file: guess plus exact/partial feedback, one valid bit
// per entry. Only instantiated when MASTERMIND_HISTORY_EN is defined.
module mastermind_hist_ram
  import mastermind_pkg::*;
#(
  parameter int unsigned PEGS      = DefPegs,
  parameter int unsigned COLOR_W   = DefColorW,
  parameter int unsigned MAX_TURNS = DefMaxTurns,
  localparam int unsigned CNT_W    = cnt_width(PEGS),
  localparam int unsigned TURN_W   = turn_width(MAX_TURNS),
  localparam int unsigned CODE_W   = PEGS * COLOR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              we,
  input  logic [TURN_W-1:0] waddr,
  input  logic [CODE_W-1:0] wguess,
  input  logic [CNT_W-1:0]  wexact,
  input  logic [CNT_W-1:0]  wpartial,
  input  logic [TURN_W-1:0] raddr,
  output logic [CODE_W-1:0] rguess,
  output logic [CNT_W-1:0]  rexact,
  output logic [CNT_W-1:0]  rpartial
);

  logic [CODE_W-1:0]    guess_mem_q   [MAX_TURNS];
  logic [CNT_W-1:0]     exact_mem_q   [MAX_TURNS];
  logic [CNT_W-1:0]     partial_mem_q [MAX_TURNS];
  logic [MAX_TURNS-1:0] valid_q;

  // Storage: clear drops every valid bit; a write fills one entry and marks it valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < MAX_TURNS; i++) begin
        guess_mem_q[i]   <= '0;
        exact_mem_q[i]   <= '0;
        partial_mem_q[i] <= '0;
      end
    end else if (clear) begin
      valid_q <= '0;
    end else if (we) begin
      for (int i = 0; i < MAX_TURNS; i++) begin
        if (waddr == TURN_W'(i)) begin
          guess_mem_q[i]   <= wguess;
          exact_mem_q[i]   <= wexact;
          partial_mem_q[i] <= wpartial;
          valid_q[i]       <= 1'b1;
        end
      end
    end
  end

  // Asynchronous read; unwritten or out-of-range entries read as zero.
  always_comb begin
    rguess   = '0;
    rexact   = '0;
    rpartial = '0;
    for (int i = 0; i < MAX_TURNS; i++) begin
      if (raddr == TURN_W'(i) && valid_q[i]) begin
        rguess   = guess_mem_q[i];
        rexact   = exact_mem_q[i];
        rpartial = partial_mem_q[i];
      end
    end
  end

endmodule

// File: rtl/mastermind_engine.sv
// Mastermind engine: holds the secret, accepts guesses over valid/ready, scores them
// sequentially (per-peg pass, then per-colour histogram pass) and tracks win/loss.
// Define MASTERMIND_HISTORY_EN to build the per-turn history buffer behind hist_*.
module mastermind_engine
  import mastermind_pkg::*;
#(
  parameter int unsigned PEGS      = DefPegs,
  parameter int unsigned COLOR_W   = DefColorW,
  parameter int unsigned MAX_TURNS = DefMaxTurns,
  localparam int unsigned CNT_W    = cnt_width(PEGS),
  localparam int unsigned TURN_W   = turn_width(MAX_TURNS),
  localparam int unsigned CODE_W   = PEGS * COLOR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              new_game,
  input  logic [CODE_W-1:0] code_in,
  input  logic              guess_valid,
  output logic              guess_ready,
  input  logic [CODE_W-1:0] guess_in,
  output logic              fb_valid,
  output logic [CNT_W-1:0]  fb_exact,
  output logic [CNT_W-1:0]  fb_partial,
  output logic [TURN_W-1:0] turn_count,
  output logic              game_won,
  output logic              game_lost,
  input  logic [TURN_W-1:0] hist_sel,
  output logic [CODE_W-1:0] hist_guess,
  output logic [CNT_W-1:0]  hist_exact,
  output logic [CNT_W-1:0]  hist_partial
);

  localparam int unsigned NumColors = 2 ** COLOR_W;
  // One extra step past the last colour is the completion cycle.
  localparam int unsigned MidxW     = COLOR_W + 1;
  localparam logic [CNT_W-1:0] LastPeg  = CNT_W'(PEGS - 1);
  localparam logic [MidxW-1:0] MatchEnd = MidxW'(NumColors);

  state_e state_q, state_d;

  logic [CODE_W-1:0] code_q, guess_q;
  logic [CNT_W-1:0]  peg_idx_q, exact_q, total_q;
  logic [MidxW-1:0]  match_idx_q;
  logic [CNT_W-1:0]  code_hist_q  [NumColors];
  logic [CNT_W-1:0]  guess_hist_q [NumColors];

  logic              fb_valid_q;
  logic [CNT_W-1:0]  fb_exact_q, fb_partial_q;
  logic [TURN_W-1:0] turn_q;
  logic              won_q, lost_q;

  logic              accept, finish, win_now, lose_now;
  logic [COLOR_W-1:0] peg_c, peg_g, color_k;
  logic [CNT_W-1:0]  bin_min, partial_now;

  // Datapath helpers: current peg colours, per-colour overlap, final tallies.
  always_comb begin
    peg_c       = COLOR_W'(peg_at(MaxCodeW'(code_q), 32'(peg_idx_q), COLOR_W));
    peg_g       = COLOR_W'(peg_at(MaxCodeW'(guess_q), 32'(peg_idx_q), COLOR_W));
    color_k     = match_idx_q[COLOR_W-1:0];
    bin_min     = (code_hist_q[color_k] < guess_hist_q[color_k]) ? code_hist_q[color_k]
                                                                 : guess_hist_q[color_k];
    partial_now = total_q - exact_q;
    win_now     = (exact_q == CNT_W'(PEGS));
    lose_now    = ((turn_q + TURN_W'(1)) == TURN_W'(MAX_TURNS));
  end

  // Next-state logic; new_game overrides everything, including a pending accept.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    if (new_game) begin
      state_d = StReady;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StReady: begin
          if (guess_valid) begin
            accept  = 1'b1;
            state_d = StCount;
          end
        end
        StCount: begin
          if (peg_idx_q == LastPeg) state_d = StMatch;
        end
        StMatch: begin
          if (match_idx_q == MatchEnd) begin
            finish  = 1'b1;
            state_d = (win_now || lose_now) ? StDone : StReady;
          end
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Scoring datapath, game bookkeeping and registered feedback outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_q       <= '0;
      guess_q      <= '0;
      peg_idx_q    <= '0;
      exact_q      <= '0;
      total_q      <= '0;
      match_idx_q  <= '0;
      fb_valid_q   <= 1'b0;
      fb_exact_q   <= '0;
      fb_partial_q <= '0;
      turn_q       <= '0;
      won_q        <= 1'b0;
      lost_q       <= 1'b0;
      for (int k = 0; k < NumColors; k++) begin
        code_hist_q[k]  <= '0;
        guess_hist_q[k] <= '0;
      end
    end else begin
      fb_valid_q <= 1'b0;
      if (new_game) begin
        code_q       <= code_in;
        turn_q       <= '0;
        won_q        <= 1'b0;
        lost_q       <= 1'b0;
        fb_exact_q   <= '0;
        fb_partial_q <= '0;
      end else begin
        if (accept) begin
          guess_q     <= guess_in;
          peg_idx_q   <= '0;
          exact_q     <= '0;
          total_q     <= '0;
          match_idx_q <= '0;
          for (int k = 0; k < NumColors; k++) begin
            code_hist_q[k]  <= '0;
            guess_hist_q[k] <= '0;
          end
        end
        if (state_q == StCount) begin
          exact_q              <= exact_q + CNT_W'(peg_c == peg_g);
          code_hist_q[peg_c]   <= code_hist_q[peg_c] + CNT_W'(1);
          guess_hist_q[peg_g]  <= guess_hist_q[peg_g] + CNT_W'(1);
          peg_idx_q            <= peg_idx_q + CNT_W'(1);
        end
        if (state_q == StMatch && !finish) begin
          total_q     <= total_q + bin_min;
          match_idx_q <= match_idx_q + MidxW'(1);
        end
        if (finish) begin
          fb_valid_q   <= 1'b1;
          fb_exact_q   <= exact_q;
          fb_partial_q <= partial_now;
          turn_q       <= turn_q + TURN_W'(1);
          won_q        <= win_now;
          lost_q       <= !win_now && lose_now;
        end
      end
    end
  end

  assign guess_ready = (state_q == StReady);
  assign fb_valid    = fb_valid_q;
  assign fb_exact    = fb_exact_q;
  assign fb_partial  = fb_partial_q;
  assign turn_count  = turn_q;
  assign game_won    = won_q;
  assign game_lost   = lost_q;

`ifdef MASTERMIND_HISTORY_EN
  mastermind_hist_ram #(
    .PEGS      (PEGS),
    .COLOR_W   (COLOR_W),
    .MAX_TURNS (MAX_TURNS)
  ) u_hist (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (new_game),
    .we       (finish),
    .waddr    (turn_q),
    .wguess   (guess_q),
    .wexact   (exact_q),
    .wpartial (partial_now),
    .raddr    (hist_sel),
    .rguess   (hist_guess),
    .rexact   (hist_exact),
    .rpartial (hist_partial)
  );
`else
  logic unused_hist_sel;
  assign unused_hist_sel = ^hist_sel;
  assign hist_guess      = '0;
  assign hist_exact      = '0;
  assign hist_partial    = '0;
`endif

endmodule

// File: doc/mastermind_engine.md
# mastermind_engine

Parametrised Mastermind game engine: holds the secret code, accepts guesses over a valid/ready handshake, and scores each guess sequentially into exact/partial counts. It keeps a per-turn history and detects win and loss. It sits between the guess-entry/PRNG logic and the feedback display path, and generalises the fixed 4-peg, 8-colour, 8-turn game to arbitrary peg count, colour width and turn limit.

## Interface
- PEGS, 4, pegs per code/guess (≥1)
- COLOR_W, 3, bits per peg colour; 2**COLOR_W colours
- MAX_TURNS, 8, guesses allowed per game (≥1)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- new_game  in  1  pulse: load code_in, clear history, start game
- code_in  in  PEGS*COLOR_W  secret code, peg i at [i*COLOR_W +: COLOR_W]
- guess_valid  in  1  guess_in presented
- guess_ready  out  1  engine accepts a guess this cycle
- guess_in  in  PEGS*COLOR_W  guess, same packing as code_in
- fb_valid  out  1  one-cycle pulse: fb_exact/fb_partial valid
- fb_exact  out  CNT_W  right colour, right position; CNT_W = $clog2(PEGS+1)
- fb_partial  out  CNT_W  right colour, wrong position
- turn_count  out  TURN_W  guesses scored this game; TURN_W = $clog2(MAX_TURNS+1)
- game_won / game_lost  out  1 each  sticky until new_game/reset
- hist_sel  in  TURN_W  history read index
- hist_guess  out  PEGS*COLOR_W  stored guess at hist_sel (combinational read)
- hist_exact / hist_partial  out  CNT_W each  stored feedback at hist_sel

## Operation
- States: IDLE → (new_game) READY → (accept) COUNT → MATCH → READY or DONE; DONE → (new_game) READY.
- Handshake: accept on guess_valid && guess_ready; guess_ready = 1 only in READY. guess_in is latched at the accepting edge.
- COUNT, PEGS cycles, one peg per cycle: exact += (g[i]==c[i]); code_hist[c[i]]++, guess_hist[g[i]]++.
- MATCH, 2**COLOR_W cycles, one colour per cycle: total += min(code_hist[k], guess_hist[k]).
- Completion: fb_partial = total − fb_exact. fb_valid pulses. The history entry is written at turn_count, then turn_count++.
- Win: fb_exact == PEGS → game_won, DONE. Else, if turn_count reaches MAX_TURNS → game_lost, DONE. Win has priority on the final turn.
- Histograms are cleared on entry to COUNT.
- Arithmetic: all counters are saturation-free. Widths are sized so that no overflow is possible (histogram bins are CNT_W).

## Timing
- Reset values: every output 0. State IDLE, histograms and history cleared.
- Latency: fb_valid is asserted exactly PEGS + 2**COLOR_W + 1 edges after the accepting edge (defaults: 13).
- Results hold after fb_valid until the next completion or new_game.
- game_won/game_lost/turn_count update on the same edge that raises fb_valid. guess_ready returns high the cycle after (READY), or stays low (DONE).
- new_game in any state, including mid-scoring:
  - aborts scoring with no fb_valid;
  - loads the code, zeroes turn_count, flags and history valid bits;
  - enters READY on the next edge.
- new_game together with guess_valid: new_game wins and the guess is not accepted.
- hist_sel ≥ turn_count: hist outputs read 0.
- reset_n asserted mid-operation: immediate return to reset values.

## Configuration
- MASTERMIND_HISTORY_EN:
  - Defined: the history buffer (MAX_TURNS entries) is built and the hist_* outputs are live.
  - Undefined: no storage, hist_* outputs are tied to 0, and hist_sel is ignored. Scoring, turn counting and win/loss behaviour are unchanged.

## Structure
- mastermind_pkg:
  - state enum (IDLE, READY, COUNT, MATCH, DONE);
  - default parameter constants;
  - width functions for CNT_W/TURN_W;
  - peg extract helper function.
- Sub-module mastermind_hist_ram: MAX_TURNS-deep register file with a write port and an asynchronous read port, storing guess and feedback plus a per-entry valid bit. It is instantiated only under MASTERMIND_HISTORY_EN.

## Test plan
- Code {4,3,2,1} (peg3..peg0), guess {1,2,3,4} → fb_exact 0, fb_partial 4, turn_count 1, fb_valid 13 cycles after accept.
- Code {1,1,2,2}, guess {1,2,1,1} → exact 1, partial 2 (duplicate-colour handling).
- Code {1,2,3,4}, guess {1,2,3,4} on turn 3 → exact 4, game_won 1, guess_ready stays 0; guess_valid held high is not accepted.
- 8 wrong guesses with MAX_TURNS=8 → game_lost 1 after the 8th fb_valid. A correct 8th guess instead → game_won 1, game_lost 0.
- new_game asserted 5 cycles into scoring → no fb_valid, turn_count 0, guess_ready 1 on the next cycle. hist_sel 0 reads 0.
- Re-parameterise PEGS=6, COLOR_W=2, MAX_TURNS=10: latency 11 cycles. Code all 3s, guess all 3s → exact 6. With the macro undefined, hist_guess is 0 throughout.
